// File: rtl/ecc_pkg.sv
// Shared types and elaboration-time helpers for the SECDED decoder.
// The codeword layout is fixed here. Bit 0 holds the overall parity p0.
// Bit k (k >= 1) holds Hamming position k. Parity bits sit at the
// power-of-two positions, and data bits fill the remaining positions in
// ascending order.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN  = 2'b00,
        ECC_CORR   = 2'b01,
        ECC_UNCORR = 2'b10
    } ecc_status_e;

    // Smallest number of Hamming parity bits that can address every
    // position of a codeword carrying data_w data bits plus p0.
    function automatic int calc_par_w(input int data_w);
        for (int p = 1; p < 31; p++) begin
            if ((1 << p) >= data_w + p + 1) begin
                return p;
            end
        end
        return 31;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Maps a Hamming position to the data bit index it carries.
    // Returns -1 for parity positions (powers of two) and for position 0.
    function automatic int pos_to_data_idx(input int pos);
        int n_par;
        n_par = 0;
        if (pos < 3 || is_pow2(pos)) begin
            return -1;
        end
        for (int k = 1; k <= pos; k = k * 2) begin
            n_par++;
        end
        return pos - n_par - 1;
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome generator. It computes the Hamming syndrome s,
// which is the XOR of the indices of all set bits at positions 1 and up.
// It also computes the overall parity q, which is the XOR of every bit
// of the codeword.
module ecc_syndrome #(
    parameter int CW_W  = 16,
    parameter int PAR_W = 4
) (
    input  logic [CW_W-1:0]  code_i,
    output logic [PAR_W-1:0] syndrome_o,
    output logic             overall_o
);

    // Fold the position index of every set bit into the syndrome.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so each loop iteration sees the previous partial XOR; clocked blocks use '<='.
        syndrome_o = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (code_i[k]) begin
                syndrome_o = syndrome_o ^ PAR_W'(k);
            end
        end
    end

    assign overall_o = ^code_i;

endmodule

// File: rtl/ecc_secded_decoder.sv
// SECDED (extended Hamming) decoder with a two-stage valid/ready pipeline.
// Stage 1 registers the codeword together with its syndrome and overall
// parity. Stage 2 applies any correction, extracts the data bits and
// registers the result.
// Optional feature: define ECC_ERR_COUNT_EN to build the saturating
// corrected and uncorrectable word counters. Without it, sb_count and
// db_count are tied to 0 and clr_counts is ignored.
module ecc_secded_decoder
    import ecc_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = calc_par_w(DATA_W),
    parameter int CNT_W  = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W+PAR_W:0]   in_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [1:0]              out_status,
    output logic [PAR_W-1:0]        out_syndrome,
    input  logic                    clr_counts,
    output logic [CNT_W-1:0]        sb_count,
    output logic [CNT_W-1:0]        db_count
);

    localparam int CW_W  = DATA_W + PAR_W + 1;
    localparam int N_POS = 1 << PAR_W;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s1_load;
    logic s2_load;

    // Stage 2 advances when it is empty or its result is being taken.
    // Stage 1 advances when it is empty or stage 2 is pulling from it.
    // Neither term looks at in_valid, so in_ready has no path from it.
    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // ------------------------------------------------------------------
    // Stage 1: capture codeword, syndrome and overall parity
    // ------------------------------------------------------------------
    logic [PAR_W-1:0] syn_d;
    logic             par_d;
    logic [CW_W-1:0]  s1_code_q;
    logic [PAR_W-1:0] s1_syn_q;
    logic             s1_par_q;

    ecc_syndrome #(
        .CW_W  (CW_W),
        .PAR_W (PAR_W)
    ) u_syndrome (
        .code_i     (in_code),
        .syndrome_o (syn_d),
        .overall_o  (par_d)
    );

    // Stage-1 payload registers load on every accepted word.
    always_ff @(posedge Clk) begin
        // NOTE: payload registers are always qualified by a valid bit, so they carry no reset; only the control state and outputs do.
        if (s1_load && in_valid) begin
            s1_code_q <= in_code;
            s1_syn_q  <= syn_d;
            s1_par_q  <= par_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decode: classify, correct, extract
    // ------------------------------------------------------------------
    logic [N_POS-1:0] pos_mask;
    logic [CW_W-1:0]  flip;
    logic [CW_W-1:0]  corr_code;
    logic [DATA_W-1:0] dec_data;
    ecc_status_e      dec_status;
    logic             unused_corr_bits;

    // A syndrome can only be corrected when it names a real position of
    // the codeword. Syndromes beyond CW_W-1 mean a multi-bit error.
    for (genvar g = 0; g < N_POS; g++) begin : g_pos_mask
        assign pos_mask[g] = (g < CW_W);
    end

    // Classify the word and build the single-bit correction mask.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        dec_status = ECC_CLEAN;
        flip       = '0;
        if (s1_par_q) begin
            if (pos_mask[s1_syn_q]) begin
                // s = 0 selects p0 itself, so the data bits remain untouched.
                dec_status = ECC_CORR;
                for (int k = 0; k < CW_W; k++) begin
                    flip[k] = (s1_syn_q == PAR_W'(k));
                end
            end else begin
                dec_status = ECC_UNCORR;
            end
        end else if (s1_syn_q != '0) begin
            // Even overall parity with a nonzero syndrome means a double error.
            dec_status = ECC_UNCORR;
        end
    end

    assign corr_code = s1_code_q ^ flip;

    // Gather the data bits from the non-power-of-two positions.
    for (genvar k = 1; k < CW_W; k++) begin : g_extract
        if (pos_to_data_idx(k) >= 0) begin : g_data
            assign dec_data[pos_to_data_idx(k)] = corr_code[k];
        end
    end

    // Parity positions are checked but never forwarded as data.
    assign unused_corr_bits = ^corr_code;

    // ------------------------------------------------------------------
    // Stage 2 registers and output port
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] out_data_q;
    ecc_status_e       out_status_q;
    logic [PAR_W-1:0]  out_syndrome_q;

    // Pipeline valid bits and result registers. The result holds while stalled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_status_q   <= ECC_CLEAN;
            out_syndrome_q <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q     <= dec_data;
                    out_status_q   <= dec_status;
                    out_syndrome_q <= s1_syn_q;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_status   = out_status_q;
    assign out_syndrome = out_syndrome_q;

    // ------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------
`ifdef ECC_ERR_COUNT_EN
    logic             out_fire;
    logic [CNT_W-1:0] sb_count_q;
    logic [CNT_W-1:0] sb_count_d;
    logic [CNT_W-1:0] db_count_q;
    logic [CNT_W-1:0] db_count_d;

    assign out_fire = out_valid_q && out_ready;

    // Count delivered words by status. Clearing wins over a same-cycle increment.
    always_comb begin
        sb_count_d = sb_count_q;
        db_count_d = db_count_q;
        if (clr_counts) begin
            sb_count_d = '0;
            db_count_d = '0;
        end else if (out_fire) begin
            if (out_status_q == ECC_CORR && sb_count_q != '1) begin
                sb_count_d = sb_count_q + CNT_W'(1);
            end
            if (out_status_q == ECC_UNCORR && db_count_q != '1) begin
                db_count_d = db_count_q + CNT_W'(1);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sb_count_q <= '0;
            db_count_q <= '0;
        end else begin
            sb_count_q <= sb_count_d;
            db_count_q <= db_count_d;
        end
    end

    assign sb_count = sb_count_q;
    assign db_count = db_count_q;
`else
    logic unused_clr_counts;

    assign unused_clr_counts = clr_counts;
    assign sb_count          = '0;
    assign db_count          = '0;
`endif

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Scoreboard bench for ecc_secded_decoder. The stimulus pushes the
// hand-computed result of each accepted codeword into a queue. A monitor
// pops one entry per output handshake and compares it with the DUT
// output. While a result is stalled, the monitor also checks it against
// the queue head on every cycle.
module tb_ecc_secded_decoder;

    localparam int DATA_W = 11;
    localparam int PAR_W  = 4;
    localparam int CW_W   = 16;
`ifdef ECC_ERR_COUNT_EN
    localparam int CNT_W  = 2;
`else
    localparam int CNT_W  = 8;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        status;
        logic [PAR_W-1:0]  syn;
        int                acc_cyc;
        bit                chk_lat;
    } exp_t;

    logic              Clk;
    logic              Reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [PAR_W-1:0]  out_syndrome;
    logic              clr_counts;
    logic [CNT_W-1:0]  sb_count;
    logic [CNT_W-1:0]  db_count;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_sb   = 0;
    int   exp_db   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    ecc_secded_decoder #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .out_syndrome (out_syndrome),
        .clr_counts   (clr_counts),
        .sb_count     (sb_count),
        .db_count     (db_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: compare on each presented result and pop on handshake.
    always @(negedge Clk) begin
        if (Reset_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data 0x%0h status %0d, expected no output", out_data, out_status);
            end else begin
                mon_e = sb_q[0];
                check("out_data", 32'(out_data), 32'(mon_e.data));
                check("out_status", 32'(out_status), 32'(mon_e.status));
                check("out_syndrome", 32'(out_syndrome), 32'(mon_e.syn));
                if (out_ready) begin
                    if (mon_e.chk_lat) begin
                        check("latency", 32'(cyc - mon_e.acc_cyc), 32'd2);
                    end
`ifdef ECC_ERR_COUNT_EN
                    if (mon_e.status == 2'b01 && exp_sb < (1 << CNT_W) - 1) exp_sb++;
                    if (mon_e.status == 2'b10 && exp_db < (1 << CNT_W) - 1) exp_db++;
`endif
                    void'(sb_q.pop_front());
                end
            end
        end
`ifdef ECC_ERR_COUNT_EN
        if (clr_counts) begin
            exp_sb = 0;
            exp_db = 0;
        end
`endif
    end

    task automatic send(input logic [CW_W-1:0] code, input logic [DATA_W-1:0] d,
                        input logic [1:0] st, input logic [PAR_W-1:0] s, input bit lat);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge Clk);
            if (in_ready) begin
                sb_q.push_back('{data: d, status: st, syn: s, acc_cyc: cyc, chk_lat: lat});
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for code 0x%0h, expected 1", code);
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_code  = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            @(negedge Clk);
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_sb_count"}, 32'(sb_count), 32'(exp_sb));
        check({tag, "_db_count"}, 32'(db_count), 32'(exp_db));
    endtask

    initial begin
        Reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_code    = '0;
        out_ready  = 1'b1;
        clr_counts = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_status", 32'(out_status), 32'd0);
        check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
        check_counts("rst");
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;

        // Basic vectors: clean all-ones, single error at 5, double error, p0 error.
        send(16'hFFFF, 11'h7FF, 2'b00, 4'h0, 1'b1);
        drain();
        send(16'h0020, 11'h000, 2'b01, 4'h5, 1'b1);
        drain();
        check_counts("single_err");
        send(16'h0028, 11'h003, 2'b10, 4'h6, 1'b1);
        send(16'hFFFE, 11'h7FF, 2'b01, 4'h0, 1'b1);
        drain();
        check_counts("double_err");

        // Further directed codewords, issued back to back.
        send(16'h0000, 11'h000, 2'b00, 4'h0, 1'b1);
        send(16'h000F, 11'h001, 2'b00, 4'h0, 1'b1);
        send(16'h020F, 11'h001, 2'b01, 4'h9, 1'b1);
        send(16'h8117, 11'h400, 2'b00, 4'h0, 1'b1);
        send(16'h0117, 11'h400, 2'b01, 4'hF, 1'b1);
        send(16'h8111, 11'h400, 2'b10, 4'h3, 1'b1);
        drain();
        check_counts("directed");

        // Four-word stream with a three-cycle consumer stall mid-stream.
        fork
            begin
                send(16'h000F, 11'h001, 2'b00, 4'h0, 1'b0);
                send(16'h0020, 11'h000, 2'b01, 4'h5, 1'b0);
                send(16'h8117, 11'h400, 2'b00, 4'h0, 1'b0);
                send(16'h0028, 11'h003, 2'b10, 4'h6, 1'b0);
            end
            begin
                @(posedge Clk);
                @(posedge Clk);
                #1 out_ready = 1'b0;
                @(negedge Clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge Clk);
                @(posedge Clk);
                @(posedge Clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_counts("stream");

`ifdef ECC_ERR_COUNT_EN
        // Clear, then saturate the 2-bit corrected counter.
        @(negedge Clk);
        #1 clr_counts = 1'b1;
        @(posedge Clk);
        #1 clr_counts = 1'b0;
        check("clr_sb_count", 32'(sb_count), 32'd0);
        check("clr_db_count", 32'(db_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(16'h0020, 11'h000, 2'b01, 4'h5, 1'b1);
        end
        drain();
        check("sat_sb_count", 32'(sb_count), 32'd3);
        check_counts("sat");

        // Clear in the same cycle as a corrected-word handshake.
        out_ready = 1'b0;
        send(16'h0020, 11'h000, 2'b01, 4'h5, 1'b0);
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(negedge Clk);
        end
        check("held_out_valid", 32'(out_valid), 32'd1);
        @(posedge Clk);
        #1;
        clr_counts = 1'b1;
        out_ready  = 1'b1;
        @(posedge Clk);
        #1 clr_counts = 1'b0;
        check("clr_prio_sb_count", 32'(sb_count), 32'd0);
        check("clr_prio_db_count", 32'(db_count), 32'd0);
        drain();
`endif

        // Reset with two words in flight.
        send(16'h000F, 11'h001, 2'b00, 4'h0, 1'b0);
        send(16'h0020, 11'h000, 2'b01, 4'h5, 1'b0);
        Reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sb_count", 32'(sb_count), 32'd0);
        check("midrst_db_count", 32'(db_count), 32'd0);
        sb_q.delete();
        exp_sb = 0;
        exp_db = 0;
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;
        send(16'h020F, 11'h001, 2'b01, 4'h9, 1'b1);
        drain();
        check_counts("postrst");
        repeat (3) @(negedge Clk);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
